cmp_capture: RTL and testbench
==============================

# cmp_capture

Receive-side companion to the comparator phase generator. It samples the asynchronous comparator decision on each `sample` strobe and undoes the chopping inversion during phase 2. It counts decision ones over a fixed window of `NSAMP` decisions aligned to the start of a phase-1 period, then presents the count through a valid/ready result port. It sits between the analog comparator output and the readout/control logic.

## Interface
- `NSAMP`, default 16: decisions per window; even, ≥2.
- `CHOP`, default 1: 1 inverts the decision taken while `cmp_p2` is high; 0 uses the decision as-is.
- `W`, default `$clog2(NSAMP+1)`: result width.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmp_p1`  in  1  phase-1 level from the phase generator (synchronous to `clk`).
- `cmp_p2`  in  1  phase-2 level, complement of `cmp_p1`.
- `sample`  in  1  one-cycle strobe: take a decision this cycle.
- `cmp_out`  in  1  comparator decision, asynchronous.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  W  count of ones in the last completed window.
- `result_valid`  out  1  `result` holds an unconsumed window.
- `overrun`  out  1  sticky: a completed window was discarded.
- `aligned`  out  1  the accumulator is inside a window.

## Operation
- `cmp_out` passes through a 2-flop synchronizer, giving `cmp_s`.
- Decision bit: `d = cmp_s ^ (CHOP & cmp_p2)`, evaluated in the cycle `sample`=1.
- State machine, two states:
  - ALIGN: ignores strobes until a strobe arrives with `cmp_p1`=1. That strobe is decision 0 of the window: `acc` = `d`, `idx` = 1, next state ACCUM.
  - ACCUM: on each strobe, `acc` += `d` and `idx` += 1.
  - When the strobe making `idx` = `NSAMP` arrives: the window completes, `acc` and `idx` reset to 0, and the state stays ACCUM. The next strobe starts the next window with no realignment.
- Phase check: a strobe at even `idx` with `cmp_p1`=0 means phase alignment was lost. In that case:
  - the partial window is discarded;
  - the state returns to ALIGN, and that strobe is not counted;
  - `overrun` is not set.
- Result register:
  - On window completion, if `result_valid`=0, or `out_ready`=1 in the same cycle, load `result` with the final count and set `result_valid`=1.
  - Otherwise keep the old result and set `overrun`=1.
- Handshake: the transfer happens in any cycle with `result_valid` & `out_ready`. `result_valid` clears the next cycle unless a new load happens in that same cycle.
  - `result` is stable while `result_valid`=1 and `out_ready`=0.
  - `out_ready` may be asserted before `result_valid` rises.
- `overrun` clears only on `reset`.
- Arithmetic: `acc` and `idx` are W bits wide. The maximum count `NSAMP` fits in W bits, so there is no saturation or wrap.

## Timing
- Reset values: `result`=0, `result_valid`=0, `overrun`=0, `aligned`=0, synchronizer flops 0, state ALIGN, `acc`=0, `idx`=0.
- `reset` mid-window discards all state. The first window after reset starts at the next qualifying phase-1 strobe.
- Synchronizer latency: a change on `cmp_out` is visible in `d` 2 clocks later. The phase generator places `sample` 2 clocks into each phase, so the decision reflects comparator state from phase start.
- Result latency: `result_valid` rises 1 clock after the final strobe of a window.
- `aligned` is 1 in ACCUM, 0 in ALIGN, registered.
- Simultaneous window completion and consumer accept (`result_valid`=1, `out_ready`=1): the new result loads, `result_valid` stays 1, and `overrun` is not set.
- `sample` while `reset`=1 is ignored.

## Structure
- Shared package `cmp_pkg`:
  - state enum `cmp_cap_state_t {ALIGN, ACCUM}`;
  - a `CMP_SYNC_STAGES=2` constant, shared with any future comparator-side blocks.
- One sub-module, `sync2`: the generic 2-flop synchronizer, reusable elsewhere.
- Window and handshake logic stay in the top module.

## Test plan
- Window count: `cmp_out`=1 constant, `CHOP`=1, `NSAMP`=16, driven by a phase generator with a 4-clock phase period. Required: `result`=8 (p2 decisions inverted), `result_valid` 1 clock after the 16th strobe.
- Chopped input: `cmp_out` follows `cmp_p1` (offset-free input pattern). Required: `result`=16. Same stimulus with `CHOP`=0: `result`=8.
- Back-pressure: `out_ready`=0 across two windows. Required: the first `result` is held, `overrun`=1 after the second completion. Then `out_ready`=1: `result_valid` drops the next clock.
- Simultaneous accept: `out_ready` pulsed exactly on the completion-load cycle. Required: the new result loads, `overrun` stays 0.
- Alignment: the first strobe after reset arrives with `cmp_p2`=1. Required: ignored, `aligned` rises on the next phase-1 strobe. Dropping one strobe mid-window returns to ALIGN with no result emitted.
- Reset at decision 9 of 16. Required: all outputs 0 the next clock, and the next result counts only post-reset decisions.

Source files
------------

// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the comparator receive path.
//   CMP_SYNC_STAGES : number of flops used to bring the asynchronous comparator
//                     decision into the clk domain.
//   cmp_cap_state_t : window state of cmp_capture (ALIGN, ACCUM).
// No ports.
// -----------------------------------------------------------------------------
package cmp_pkg;

  localparam int CMP_SYNC_STAGES = 2;

  typedef enum logic {
    ALIGN = 1'b0,
    ACCUM = 1'b1
  } cmp_cap_state_t;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Generic multi-flop synchronizer for a single asynchronous bit. The depth
// comes from cmp_pkg::CMP_SYNC_STAGES (two flops).
// Ports:
//   clk_i   : destination clock
//   reset_i : synchronous active-high reset, clears every stage to 0
//   d_i     : asynchronous input
//   q_o     : synchronized output, CMP_SYNC_STAGES clocks behind d_i
// -----------------------------------------------------------------------------
module sync2
  import cmp_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [CMP_SYNC_STAGES-1:0] sync_q;

  // Shift chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[CMP_SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[CMP_SYNC_STAGES-1];

endmodule

// File: rtl/cmp_capture.sv
// -----------------------------------------------------------------------------
// cmp_capture
// Samples the comparator decision on each sample strobe, undoes the chopping
// inversion taken during phase 2, counts ones over windows of NSAMP decisions
// aligned to a phase-1 strobe, and offers each count on a valid/ready port.
// Parameters:
//   NSAMP : decisions per window (even, >= 2)
//   CHOP  : 1 inverts decisions taken while cmp_p2 is high
//   W     : result width, wide enough to hold NSAMP
// Ports:
//   clk          : sole clock, rising edge
//   reset        : synchronous active-high reset
//   cmp_p1       : phase-1 level (synchronous to clk)
//   cmp_p2       : phase-2 level (complement of cmp_p1)
//   sample       : one-cycle strobe, take a decision this cycle
//   cmp_out      : asynchronous comparator decision
//   out_ready    : consumer accepts result
//   result       : ones counted in the last completed window
//   result_valid : result holds an unconsumed window
//   overrun      : sticky, a completed window was dropped
//   aligned      : accumulator is inside a window
// -----------------------------------------------------------------------------
module cmp_capture
  import cmp_pkg::*;
#(
  parameter int NSAMP = 16,
  parameter bit CHOP  = 1'b1,
  parameter int W     = $clog2(NSAMP + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmp_p1,
  input  logic         cmp_p2,
  input  logic         sample,
  input  logic         cmp_out,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         overrun,
  output logic         aligned
);

  logic           cmp_s;
  logic           dec_s;
  cmp_cap_state_t state_q, state_d;
  logic [W-1:0]   acc_q, acc_d, idx_q, idx_d;
  logic [W-1:0]   acc_inc_s, idx_inc_s, dec_ext_s;
  logic           done_s;
  logic [W-1:0]   result_q, result_d;
  logic           valid_q, valid_d;
  logic           overrun_q, overrun_d;
  logic           aligned_q, aligned_d;

  sync2 u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (cmp_out),
    .q_o     (cmp_s)
  );

  // Phase-2 decisions were taken with swapped comparator inputs.
  assign dec_s     = cmp_s ^ (CHOP & cmp_p2);
  assign dec_ext_s = {{(W-1){1'b0}}, dec_s};
  assign acc_inc_s = acc_q + dec_ext_s;
  assign idx_inc_s = idx_q + {{(W-1){1'b0}}, 1'b1};

  // Window state machine: alignment, accumulation, completion.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    done_s  = 1'b0;
    case (state_q)
      ALIGN: begin
        if (sample && cmp_p1) begin
          acc_d   = dec_ext_s;
          idx_d   = {{(W-1){1'b0}}, 1'b1};
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (sample) begin
          // Even positions must fall in phase 1; otherwise a strobe was lost.
          if (!idx_q[0] && !cmp_p1) begin
            acc_d   = '0;
            idx_d   = '0;
            state_d = ALIGN;
          end else if (idx_inc_s == W'(NSAMP)) begin
            done_s = 1'b1;
            acc_d  = '0;
            idx_d  = '0;
          end else begin
            acc_d = acc_inc_s;
            idx_d = idx_inc_s;
          end
        end
      end
      default: begin
        state_d = ALIGN;
        acc_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Result register and handshake; a completion may load in the accept cycle.
  always_comb begin
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (done_s) begin
      if (!valid_q || out_ready) begin
        result_d = acc_inc_s;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    aligned_d = (state_d == ACCUM);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ALIGN;
      acc_q     <= '0;
      idx_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      aligned_q <= aligned_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;
  assign aligned      = aligned_q;

endmodule

// File: tb/tb_cmp_capture.sv
// -----------------------------------------------------------------------------
// tb_cmp_capture
// Directed bench for cmp_capture. A bench-side phase generator runs an 8-clock
// cycle (4 clocks phase 1, 4 clocks phase 2) with a sample strobe 2 clocks into
// each phase. Two instances share the stimulus: dut (CHOP=1) and dut_nc (CHOP=0).
// -----------------------------------------------------------------------------
module tb_cmp_capture;

  localparam int NSAMP = 16;
  localparam int W     = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, cmp_p1, cmp_p2, sample, cmp_out, out_ready;
  logic [W-1:0] result, result_nc;
  logic         result_valid, overrun, aligned;
  logic         result_valid_nc, overrun_nc, aligned_nc;

  int n_cmp = 0;
  int n_bad = 0;
  int pc = 0;
  int strobes = 0;
  bit smp_en = 1'b1;
  bit follow = 1'b0;
  bit const_val = 1'b1;

  cmp_capture #(.NSAMP(NSAMP), .CHOP(1'b1), .W(W)) dut (
    .clk(clk), .reset(reset), .cmp_p1(cmp_p1), .cmp_p2(cmp_p2),
    .sample(sample), .cmp_out(cmp_out), .out_ready(out_ready),
    .result(result), .result_valid(result_valid), .overrun(overrun),
    .aligned(aligned)
  );

  cmp_capture #(.NSAMP(NSAMP), .CHOP(1'b0), .W(W)) dut_nc (
    .clk(clk), .reset(reset), .cmp_p1(cmp_p1), .cmp_p2(cmp_p2),
    .sample(sample), .cmp_out(cmp_out), .out_ready(out_ready),
    .result(result_nc), .result_valid(result_valid_nc), .overrun(overrun_nc),
    .aligned(aligned_nc)
  );

  // One clock of the phase generator; outputs are settled #1 after the edge.
  task automatic cyc();
    cmp_p1  = (pc < 4);
    cmp_p2  = ~cmp_p1;
    sample  = smp_en && ((pc == 2) || (pc == 6));
    cmp_out = follow ? cmp_p1 : const_val;
    if (sample && !reset) strobes++;
    @(posedge clk);
    #1;
    pc = (pc + 1) % 8;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_strobes(input int n);
    int guard;
    guard = 0;
    strobes = 0;
    while (strobes < n && guard < 8 * n + 16) begin
      cyc();
      guard++;
    end
    if (strobes < n) begin
      n_cmp++; n_bad++;
      $display("FAIL strobe_budget: got %0d strobes want %0d", strobes, n);
    end
  endtask

  task automatic do_reset(input int start_pc);
    reset = 1'b1;
    cycn(2);
    reset = 1'b0;
    pc = start_pc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycn(3);
    n_cmp++; if (result !== 5'd0) begin n_bad++; $display("FAIL rst_result: got %0d want 0", result); end
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", result_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL rst_aligned: got %b want 0", aligned); end
    reset = 1'b0;
  endtask

  task automatic test_window_count();
    follow = 1'b0; const_val = 1'b1; out_ready = 1'b0;
    do_reset(0);
    run_strobes(15);
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL win_early_valid: got %b want 0", result_valid); end
    n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL win_aligned: got %b want 1", aligned); end
    run_strobes(1);
    n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL win_valid: got %b want 1", result_valid); end
    n_cmp++; if (result !== 5'd8) begin n_bad++; $display("FAIL win_result: got %0d want 8", result); end
    n_cmp++; if (result_nc !== 5'd16) begin n_bad++; $display("FAIL win_result_nochop: got %0d want 16", result_nc); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL win_consume: got %b want 0", result_valid); end
  endtask

  task automatic test_chopped();
    follow = 1'b1; out_ready = 1'b0;
    do_reset(0);
    run_strobes(16);
    n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL chop_valid: got %b want 1", result_valid); end
    n_cmp++; if (result !== 5'd16) begin n_bad++; $display("FAIL chop_result: got %0d want 16", result); end
    n_cmp++; if (result_nc !== 5'd8) begin n_bad++; $display("FAIL chop_result_nochop: got %0d want 8", result_nc); end
  endtask

  task automatic test_back_pressure();
    follow = 1'b0; const_val = 1'b1; out_ready = 1'b0;
    do_reset(0);
    run_strobes(16);
    n_cmp++; if (result !== 5'd8) begin n_bad++; $display("FAIL bp_first: got %0d want 8", result); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL bp_ovr_early: got %b want 0", overrun); end
    follow = 1'b1;
    run_strobes(16);
    n_cmp++; if (result !== 5'd8) begin n_bad++; $display("FAIL bp_held: got %0d want 8", result); end
    n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", result_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL bp_overrun: got %b want 1", overrun); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drop: got %b want 0", result_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL bp_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_simultaneous();
    follow = 1'b0; const_val = 1'b1; out_ready = 1'b0;
    do_reset(0);
    run_strobes(16);
    follow = 1'b1;
    run_strobes(15);
    cycn(3);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_cmp++; if (result !== 5'd16) begin n_bad++; $display("FAIL sim_result: got %0d want 16", result); end
    n_cmp++; if (result_nc !== 5'd8) begin n_bad++; $display("FAIL sim_result_nochop: got %0d want 8", result_nc); end
    n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL sim_valid: got %b want 1", result_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL sim_overrun: got %b want 0", overrun); end
    cyc();
    n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL sim_hold: got %b want 1", result_valid); end
  endtask

  task automatic test_alignment();
    follow = 1'b0; const_val = 1'b1; out_ready = 1'b0;
    do_reset(4);
    cycn(3);
    n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL al_p2_ignored: got %b want 0", aligned); end
    cycn(3);
    cyc();
    n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL al_rise: got %b want 1", aligned); end
    cycn(3);
    smp_en = 1'b0;
    cyc();
    smp_en = 1'b1;
    cycn(4);
    n_cmp++; if (aligned !== 1'b1) begin n_bad++; $display("FAIL al_odd_ok: got %b want 1", aligned); end
    cycn(4);
    n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL al_lost: got %b want 0", aligned); end
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL al_no_result: got %b want 0", result_valid); end
    run_strobes(16);
    n_cmp++; if (result !== 5'd8 || result_valid !== 1'b1) begin
      n_bad++; $display("FAIL al_realign: got %0d/%b want 8/1", result, result_valid);
    end
  endtask

  task automatic test_reset_mid();
    follow = 1'b0; const_val = 1'b1; out_ready = 1'b0;
    do_reset(0);
    run_strobes(32);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL rm_pre_overrun: got %b want 1", overrun); end
    follow = 1'b1;
    run_strobes(9);
    cycn(3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    follow = 1'b0;
    n_cmp++; if (result !== 5'd0) begin n_bad++; $display("FAIL rm_result: got %0d want 0", result); end
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", result_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rm_overrun: got %b want 0", overrun); end
    n_cmp++; if (aligned !== 1'b0) begin n_bad++; $display("FAIL rm_aligned: got %b want 0", aligned); end
    run_strobes(15);
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rm_early: got %b want 0", result_valid); end
    run_strobes(1);
    n_cmp++; if (result !== 5'd8 || result_valid !== 1'b1) begin
      n_bad++; $display("FAIL rm_next: got %0d/%b want 8/1", result, result_valid);
    end
  endtask

  initial begin
    reset = 1'b1; cmp_p1 = 1'b1; cmp_p2 = 1'b0; sample = 1'b0;
    cmp_out = 1'b0; out_ready = 1'b0;
    test_reset();
    test_window_count();
    test_chopped();
    test_back_pressure();
    test_simultaneous();
    test_alignment();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
